// File: rtl/idex_stage_if.sv
// rtl/idex_stage_if.sv - ID-to-EX bundle: decoded control, operands and stall/flush wires
interface intf_id;
  logic        Stall;
  logic        Flush;
  logic [4:0]  ALUOp;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic        RegDst;
  logic        Link;
  logic        ALUSrcImm;
  logic        Trap;
  logic        TrapCond;
  logic        LLSC;
  logic        MemRead;
  logic        MemWrite;
  logic        MemHalf;
  logic        MemByte;
  logic        MemSignExtend;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ReadData1_End;
  logic [31:0] ReadData2_End;
  logic [31:0] ExtImmOut;
  logic [7:0]  DP_Hazards;

  modport id_drv (
    output Stall, Flush, ALUOp, Rs, Rt, RegDst, Link, ALUSrcImm, Trap, TrapCond,
           LLSC, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, RegWrite,
           MemtoReg, ReadData1_End, ReadData2_End, ExtImmOut, DP_Hazards
  );

  modport idex_in (
    input  Stall, Flush, ALUOp, Rs, Rt, RegDst, Link, ALUSrcImm, Trap, TrapCond,
           LLSC, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, RegWrite,
           MemtoReg, ReadData1_End, ReadData2_End, ExtImmOut, DP_Hazards
  );
endinterface

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with hold, bubble insertion and bubble counter
module idex_stage #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic          clk,
  input  logic          rst_n,
  intf_id.idex_in       id,
  input  logic          ex_stall,
  output logic [4:0]    ex_alu_op,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [7:0]    ex_hazards,
  output logic          ex_link,
  output logic          ex_alusrc_imm,
  output logic          ex_trap,
  output logic          ex_trap_cond,
  output logic          ex_llsc,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_half,
  output logic          ex_mem_byte,
  output logic          ex_mem_sign_extend,
  output logic          ex_reg_write,
  output logic          ex_memto_reg,
  output logic [31:0]   ex_read_data1,
  output logic [31:0]   ex_read_data2,
  output logic [31:0]   ex_ext_imm,
  output logic          ex_valid,
  output logic [15:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } action_e;

  action_e     action;

  logic [4:0]  alu_op_q, alu_op_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  hazards_q, hazards_d;
  logic        link_q, link_d;
  logic        alusrc_imm_q, alusrc_imm_d;
  logic        trap_q, trap_d;
  logic        trap_cond_q, trap_cond_d;
  logic        llsc_q, llsc_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_half_q, mem_half_d;
  logic        mem_byte_q, mem_byte_d;
  logic        mem_sign_extend_q, mem_sign_extend_d;
  logic        reg_write_q, reg_write_d;
  logic        memto_reg_q, memto_reg_d;
  logic [31:0] read_data1_q, read_data1_d;
  logic [31:0] read_data2_q, read_data2_d;
  logic [31:0] ext_imm_q, ext_imm_d;
  logic        valid_q, valid_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [4:0]  load_rd;

  // Downstream hold dominates, so a stalled instruction is never replaced or duplicated
  always_comb begin
    if (ex_stall) begin
      action = ACT_HOLD;
    end else if (id.Stall || id.Flush) begin
      action = ACT_BUBBLE;
    end else begin
      action = ACT_LOAD;
    end
  end

  always_comb begin
    if (id.Link) begin
      load_rd = LINK_REG;
    end else if (id.RegDst) begin
      load_rd = id.ExtImmOut[15:11];
    end else begin
      load_rd = id.Rt;
    end
  end

  always_comb begin
    alu_op_d          = alu_op_q;
    rs_d              = rs_q;
    rt_d              = rt_q;
    rd_d              = rd_q;
    hazards_d         = hazards_q;
    link_d            = link_q;
    alusrc_imm_d      = alusrc_imm_q;
    trap_d            = trap_q;
    trap_cond_d       = trap_cond_q;
    llsc_d            = llsc_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_half_d        = mem_half_q;
    mem_byte_d        = mem_byte_q;
    mem_sign_extend_d = mem_sign_extend_q;
    reg_write_d       = reg_write_q;
    memto_reg_d       = memto_reg_q;
    read_data1_d      = read_data1_q;
    read_data2_d      = read_data2_q;
    ext_imm_d         = ext_imm_q;
    valid_d           = valid_q;
    bubble_cnt_d      = bubble_cnt_q;

    case (action)
      ACT_LOAD: begin
        alu_op_d          = id.ALUOp;
        rs_d              = id.Rs;
        rt_d              = id.Rt;
        rd_d              = load_rd;
        hazards_d         = id.DP_Hazards;
        link_d            = id.Link;
        alusrc_imm_d      = id.ALUSrcImm;
        trap_d            = id.Trap;
        trap_cond_d       = id.TrapCond;
        llsc_d            = id.LLSC;
        mem_read_d        = id.MemRead;
        mem_write_d       = id.MemWrite;
        mem_half_d        = id.MemHalf;
        mem_byte_d        = id.MemByte;
        mem_sign_extend_d = id.MemSignExtend;
        reg_write_d       = id.RegWrite;
        memto_reg_d       = id.MemtoReg;
        read_data1_d      = id.ReadData1_End;
        read_data2_d      = id.ReadData2_End;
        ext_imm_d         = id.ExtImmOut;
        valid_d           = 1'b1;
      end
      ACT_BUBBLE: begin
        // Only side-effecting controls and register ids are cleared; operands stay put
        alu_op_d     = 5'd0;
        rs_d         = 5'd0;
        rt_d         = 5'd0;
        rd_d         = 5'd0;
        hazards_d    = 8'h00;
        link_d       = 1'b0;
        trap_d       = 1'b0;
        llsc_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        memto_reg_d  = 1'b0;
        valid_d      = 1'b0;
        if (bubble_cnt_q != 16'hFFFF) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q          <= 5'd0;
      rs_q              <= 5'd0;
      rt_q              <= 5'd0;
      rd_q              <= 5'd0;
      hazards_q         <= 8'h00;
      link_q            <= 1'b0;
      alusrc_imm_q      <= 1'b0;
      trap_q            <= 1'b0;
      trap_cond_q       <= 1'b0;
      llsc_q            <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_half_q        <= 1'b0;
      mem_byte_q        <= 1'b0;
      mem_sign_extend_q <= 1'b0;
      reg_write_q       <= 1'b0;
      memto_reg_q       <= 1'b0;
      read_data1_q      <= 32'h0;
      read_data2_q      <= 32'h0;
      ext_imm_q         <= 32'h0;
      valid_q           <= 1'b0;
      bubble_cnt_q      <= 16'h0000;
    end else begin
      alu_op_q          <= alu_op_d;
      rs_q              <= rs_d;
      rt_q              <= rt_d;
      rd_q              <= rd_d;
      hazards_q         <= hazards_d;
      link_q            <= link_d;
      alusrc_imm_q      <= alusrc_imm_d;
      trap_q            <= trap_d;
      trap_cond_q       <= trap_cond_d;
      llsc_q            <= llsc_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_half_q        <= mem_half_d;
      mem_byte_q        <= mem_byte_d;
      mem_sign_extend_q <= mem_sign_extend_d;
      reg_write_q       <= reg_write_d;
      memto_reg_q       <= memto_reg_d;
      read_data1_q      <= read_data1_d;
      read_data2_q      <= read_data2_d;
      ext_imm_q         <= ext_imm_d;
      valid_q           <= valid_d;
      bubble_cnt_q      <= bubble_cnt_d;
    end
  end

  assign ex_alu_op          = alu_op_q;
  assign ex_rs              = rs_q;
  assign ex_rt              = rt_q;
  assign ex_rd              = rd_q;
  assign ex_hazards         = hazards_q;
  assign ex_link            = link_q;
  assign ex_alusrc_imm      = alusrc_imm_q;
  assign ex_trap            = trap_q;
  assign ex_trap_cond       = trap_cond_q;
  assign ex_llsc            = llsc_q;
  assign ex_mem_read        = mem_read_q;
  assign ex_mem_write       = mem_write_q;
  assign ex_mem_half        = mem_half_q;
  assign ex_mem_byte        = mem_byte_q;
  assign ex_mem_sign_extend = mem_sign_extend_q;
  assign ex_reg_write       = reg_write_q;
  assign ex_memto_reg       = memto_reg_q;
  assign ex_read_data1      = read_data1_q;
  assign ex_read_data2      = read_data2_q;
  assign ex_ext_imm         = ext_imm_q;
  assign ex_valid           = valid_q;
  assign bubble_cnt         = bubble_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - vector table, directed corner sequences and random run against a slot model
module tb_idex_stage;

  localparam logic [4:0] LINK = 5'd31;

  typedef struct packed {
    logic        stall, flush, ex_stall;
    logic [4:0]  alu_op, rs, rt;
    logic        regdst, link, alusrc, trap, trapcond, llsc;
    logic        mr, mw, mh, mb, mse, rw, m2r;
    logic [31:0] rd1, rd2, imm;
    logic [7:0]  haz;
  } in_t;

  typedef struct packed {
    logic [4:0]  alu_op, rs, rt, rd;
    logic [7:0]  haz;
    logic        link, alusrc, trap, trapcond, llsc;
    logic        mr, mw, mh, mb, mse, rw, m2r;
    logic [31:0] rd1, rd2, imm;
    logic        valid;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    in_t         vin;
    logic [4:0]  e_rd;
    logic        e_valid;
    logic        e_rw;
    logic [31:0] e_imm;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_stall;
  logic [4:0]  ex_alu_op, ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_hazards;
  logic ex_link, ex_alusrc_imm, ex_trap, ex_trap_cond, ex_llsc, ex_mem_read, ex_mem_write;
  logic ex_mem_half, ex_mem_byte, ex_mem_sign_extend, ex_reg_write, ex_memto_reg, ex_valid;
  logic [31:0] ex_read_data1, ex_read_data2, ex_ext_imm;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;
  out_t exp_o;

  intf_id id_if ();

  idex_stage #(.LINK_REG(LINK)) dut (
    .clk(clk), .rst_n(rst_n), .id(id_if), .ex_stall(ex_stall),
    .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_hazards(ex_hazards), .ex_link(ex_link), .ex_alusrc_imm(ex_alusrc_imm),
    .ex_trap(ex_trap), .ex_trap_cond(ex_trap_cond), .ex_llsc(ex_llsc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_half(ex_mem_half),
    .ex_mem_byte(ex_mem_byte), .ex_mem_sign_extend(ex_mem_sign_extend),
    .ex_reg_write(ex_reg_write), .ex_memto_reg(ex_memto_reg),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_ext_imm(ex_ext_imm),
    .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    out_t o;
    o = '{ex_alu_op, ex_rs, ex_rt, ex_rd, ex_hazards, ex_link, ex_alusrc_imm, ex_trap,
          ex_trap_cond, ex_llsc, ex_mem_read, ex_mem_write, ex_mem_half, ex_mem_byte,
          ex_mem_sign_extend, ex_reg_write, ex_memto_reg, ex_read_data1, ex_read_data2,
          ex_ext_imm, ex_valid, bubble_cnt};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk_all(input string nm);
    out_t g;
    g = dut_out();
    checks++;
    if (g !== exp_o) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, g, exp_o);
    end
  endtask

  task automatic drive(input in_t v);
    ex_stall               = v.ex_stall;
    id_if.Stall            = v.stall;
    id_if.Flush            = v.flush;
    id_if.ALUOp            = v.alu_op;
    id_if.Rs               = v.rs;
    id_if.Rt               = v.rt;
    id_if.RegDst           = v.regdst;
    id_if.Link             = v.link;
    id_if.ALUSrcImm        = v.alusrc;
    id_if.Trap             = v.trap;
    id_if.TrapCond         = v.trapcond;
    id_if.LLSC             = v.llsc;
    id_if.MemRead          = v.mr;
    id_if.MemWrite         = v.mw;
    id_if.MemHalf          = v.mh;
    id_if.MemByte          = v.mb;
    id_if.MemSignExtend    = v.mse;
    id_if.RegWrite         = v.rw;
    id_if.MemtoReg         = v.m2r;
    id_if.ReadData1_End    = v.rd1;
    id_if.ReadData2_End    = v.rd2;
    id_if.ExtImmOut        = v.imm;
    id_if.DP_Hazards       = v.haz;
  endtask

  // Model: the EX slot either keeps its instruction, becomes an empty slot, or takes the ID one
  task automatic model_edge(input in_t v);
    if (v.ex_stall) begin
    end else if (v.stall || v.flush) begin
      exp_o.valid = 0; exp_o.rw = 0; exp_o.mr = 0; exp_o.mw = 0; exp_o.trap = 0;
      exp_o.llsc = 0; exp_o.link = 0; exp_o.m2r = 0; exp_o.haz = 0; exp_o.alu_op = 0;
      exp_o.rd = 0; exp_o.rs = 0; exp_o.rt = 0;
      exp_o.cnt = (int'(exp_o.cnt) + 1 > 65535) ? 16'hFFFF : exp_o.cnt + 16'd1;
    end else begin
      exp_o.alu_op = v.alu_op; exp_o.rs = v.rs; exp_o.rt = v.rt; exp_o.haz = v.haz;
      exp_o.rd = v.link ? LINK : (v.regdst ? v.imm[15:11] : v.rt);
      exp_o.link = v.link; exp_o.alusrc = v.alusrc; exp_o.trap = v.trap;
      exp_o.trapcond = v.trapcond; exp_o.llsc = v.llsc; exp_o.mr = v.mr; exp_o.mw = v.mw;
      exp_o.mh = v.mh; exp_o.mb = v.mb; exp_o.mse = v.mse; exp_o.rw = v.rw; exp_o.m2r = v.m2r;
      exp_o.rd1 = v.rd1; exp_o.rd2 = v.rd2; exp_o.imm = v.imm; exp_o.valid = 1;
    end
  endtask

  task automatic cycle(input in_t v, input string nm);
    drive(v);
    @(posedge clk);
    model_edge(v);
    #1;
    chk_all(nm);
  endtask

  task automatic do_reset();
    #3 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    exp_o = '0;
    chk_all("reset_release");
  endtask

  function automatic in_t rand_in();
    in_t v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom};
    v.ex_stall = ($urandom_range(0, 3) == 0);
    v.stall    = ($urandom_range(0, 4) == 0);
    v.flush    = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  vec_t vt[7];
  in_t  v;
  out_t snap;

  initial begin
    drive('0);
    exp_o = '0;
    #2 chk_all("reset_state");
    @(posedge clk);
    #1 rst_n = 1;
    chk_all("after_release");

    v = '0; v.alu_op = 5'd2; v.rt = 5'd9; v.regdst = 1; v.imm = 32'h0000_5800; v.rw = 1;
    vt[0] = '{v, 5'd11, 1'b1, 1'b1, 32'h0000_5800, 16'd0};
    v = '0; v.link = 1; v.regdst = 1; v.rw = 1; v.rt = 5'd3; v.imm = 32'h0000_0004;
    vt[1] = '{v, 5'd31, 1'b1, 1'b1, 32'h0000_0004, 16'd0};
    v = '0; v.rt = 5'd7; v.rw = 1; v.imm = 32'h1234_0010;
    vt[2] = '{v, 5'd7, 1'b1, 1'b1, 32'h1234_0010, 16'd0};
    v = '0; v.flush = 1; v.rw = 1; v.imm = 32'hAAAA_AAAA;
    vt[3] = '{v, 5'd0, 1'b0, 1'b0, 32'h1234_0010, 16'd1};
    v = '0; v.ex_stall = 1; v.stall = 1; v.rw = 1;
    vt[4] = '{v, 5'd0, 1'b0, 1'b0, 32'h1234_0010, 16'd1};
    v = '0; v.stall = 1; v.flush = 1; v.rw = 1;
    vt[5] = '{v, 5'd0, 1'b0, 1'b0, 32'h1234_0010, 16'd2};
    v = '0; v.regdst = 1; v.rt = 5'd2; v.imm = 32'hFFFF_F800;
    vt[6] = '{v, 5'd31, 1'b1, 1'b0, 32'hFFFF_F800, 16'd2};

    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].vin, $sformatf("vec%0d_all", i));
      chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_rw", i), 32'(ex_reg_write), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d_imm", i), ex_ext_imm, vt[i].e_imm);
      chk($sformatf("vec%0d_cnt", i), 32'(bubble_cnt), 32'(vt[i].e_cnt));
    end

    // Store followed by three ID stalls
    do_reset();
    v = '0; v.mw = 1; v.rd2 = 32'hDEAD_BEEF; v.rt = 5'd4;
    cycle(v, "store_load");
    chk("store_mw", 32'(ex_mem_write), 32'd1);
    for (int i = 0; i < 3; i++) begin
      v = '0; v.stall = 1; v.mw = 1; v.rd2 = 32'h0BAD_0BAD;
      cycle(v, "store_stall");
      chk("store_stall_mw", 32'(ex_mem_write), 32'd0);
      chk("store_stall_valid", 32'(ex_valid), 32'd0);
      chk("store_stall_rd2", ex_read_data2, 32'hDEAD_BEEF);
    end
    chk("store_stall_cnt", 32'(bubble_cnt), 32'd3);

    // Downstream hold masks a flush, then the flush bubbles once on release
    v = '0; v.mr = 1; v.m2r = 1; v.rw = 1; v.rt = 5'd12; v.rd1 = 32'h1111_2222;
    cycle(v, "ld_load");
    snap = dut_out();
    for (int i = 0; i < 2; i++) begin
      v = '0; v.ex_stall = 1; v.flush = 1; v.mw = 1; v.rt = 5'd1;
      cycle(v, "hold_flush");
      checks++;
      if (dut_out() !== snap) begin
        errors++;
        $display("FAIL hold_flush_unchanged got=%h want=%h", dut_out(), snap);
      end
    end
    v = '0; v.flush = 1; v.rw = 1;
    cycle(v, "flush_release");
    chk("flush_release_valid", 32'(ex_valid), 32'd0);
    chk("flush_release_cnt", 32'(bubble_cnt), 32'd4);

    // Asynchronous reset with a held register-writing instruction in EX
    v = '0; v.rw = 1; v.rt = 5'd5; v.rd1 = 32'h5555_5555;
    cycle(v, "rw_load");
    v.ex_stall = 1;
    drive(v);
    #3 rst_n = 0;
    #1;
    chk("async_rw", 32'(ex_reg_write), 32'd0);
    chk("async_valid", 32'(ex_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    exp_o = '0;
    chk_all("post_reset_all_zero");
    v = '0; v.stall = 1;
    cycle(v, "post_reset_bubble");

    // Randomised run
    for (int i = 0; i < 400; i++) begin
      cycle(rand_in(), "random");
    end

    // Saturation
    do_reset();
    v = '0; v.stall = 1;
    drive(v);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      model_edge(v);
    end
    #1;
    chk("sat_preset", 32'(bubble_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      cycle(v, "sat_more");
    end
    chk("sat_final", 32'(bubble_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
